// File: rtl/platform_scroller.sv
// platform_scroller
//   Owns the 16-entry platform table (X/Y centres) used by the doodle
//   physics stage. A load request builds the initial staircase layout. A
//   refresh request latches the doodle's upward displacement, shifts every
//   platform down by it, and respawns the platforms that fall off the
//   bottom at the top with a pseudo-random X. trigger acknowledges the
//   scroll with a level handshake.
//
// Ports
//   Clk          in   system clock
//   Reset        in   asynchronous active-low reset
//   loadplat     in   level, build the initial layout (wins over refresh_en)
//   refresh_en   in   scroll request, held until trigger is seen
//   plat_temp_Y  in   [9:0] two's-complement doodle Y velocity
//   plat_x       out  [NUM_PLAT*9-1:0] packed X centres, entry i at [9i+:9]
//   plat_y       out  [NUM_PLAT*9-1:0] packed Y centres, same packing
//   plat_sizeX   out  [8:0] platform half-width
//   plat_sizeY   out  [8:0] platform half-height
//   trigger      out  scroll acknowledge, high in DONE
//   busy         out  high in any state other than IDLE
//   countingss   out  [15:0] saturating sum of scroll displacements
//
// Build option
//   SCROLL_SCORE_EN  when defined, countingss accumulates every latched
//                    displacement; otherwise it is tied to 0.

module platform_scroller #(
  parameter int          NUM_PLAT     = 16,
  parameter int          SCREEN_Y_MAX = 479,
  parameter int          ROW_PITCH    = 30,
  parameter int          X_BASE       = 40,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter int          PLAT_SIZE_X  = 20,
  parameter int          PLAT_SIZE_Y  = 3
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  loadplat,
  input  logic                  refresh_en,
  input  logic [9:0]            plat_temp_Y,
  output logic [NUM_PLAT*9-1:0] plat_x,
  output logic [NUM_PLAT*9-1:0] plat_y,
  output logic [8:0]            plat_sizeX,
  output logic [8:0]            plat_sizeY,
  output logic                  trigger,
  output logic                  busy,
  output logic [15:0]           countingss
);

  typedef enum logic [2:0] {IDLE, LOAD, LATCH, SCROLL, DONE} state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_PLAT - 1);
  localparam logic [8:0] X_START  = 9'd320;

  state_t      state, state_next;
  logic [3:0]  idx;
  logic [4:0]  d;
  logic [15:0] lfsr;
  logic [8:0]  x_tab [NUM_PLAT];
  logic [8:0]  y_tab [NUM_PLAT];

  logic [15:0] lfsr_next;
  logic [8:0]  spawn_x;
  logic [8:0]  load_y;
  logic [9:0]  ny;
  logic        wrap;
  logic [9:0]  mag;
  logic [4:0]  d_in;

  // Fibonacci taps 16,14,13,11 (1-based), shifted left into bit 0.
  assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  // Spawn range 40..551 is stored in a 9-bit field, so it wraps modulo 512.
  assign spawn_x   = 9'(X_BASE) + lfsr[8:0];
  assign load_y    = 9'(SCREEN_Y_MAX - ROW_PITCH * int'(idx));
  assign ny        = {1'b0, y_tab[idx]} + {5'd0, d};
  assign wrap      = ny > 10'(SCREEN_Y_MAX);
  // Upward (negative) velocity becomes a downward scroll, clamped to 31.
  assign mag       = ~plat_temp_Y + 10'd1;
  assign d_in      = plat_temp_Y[9] ? ((mag > 10'd31) ? 5'd31 : mag[4:0]) : 5'd0;

  assign plat_sizeX = 9'(PLAT_SIZE_X);
  assign plat_sizeY = 9'(PLAT_SIZE_Y);
  assign trigger    = (state == DONE);
  assign busy       = (state != IDLE);

  for (genvar i = 0; i < NUM_PLAT; i++) begin : g_pack
    assign plat_x[9*i +: 9] = x_tab[i];
    assign plat_y[9*i +: 9] = y_tab[i];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: the default assignment first means no path leaves state_next
  // unassigned, so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (loadplat)        state_next = LOAD;
               else if (refresh_en) state_next = LATCH;
      LOAD:    if (idx == LAST_IDX) state_next = IDLE;
      LATCH:                        state_next = SCROLL;
      SCROLL:  if (idx == LAST_IDX) state_next = DONE;
      DONE:    if (!refresh_en)     state_next = IDLE;
      default:                      state_next = IDLE;
    endcase
  end

  // NOTE: the table is a register file, not a RAM macro: it must read as all
  // zeros out of reset, so every entry is cleared explicitly.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NUM_PLAT; i++) begin
        x_tab[i] <= '0;
        y_tab[i] <= '0;
      end
      lfsr <= LFSR_SEED;
      idx  <= '0;
      d    <= '0;
    end else begin
      case (state)
        IDLE: if (state_next == LOAD) begin
          idx  <= '0;
          lfsr <= LFSR_SEED;
        end
        LOAD: begin
          y_tab[idx] <= load_y;
          // Entry 0 is the fixed start platform under the doodle; it does
          // not consume a random value.
          if (idx == '0) begin
            x_tab[idx] <= X_START;
          end else begin
            x_tab[idx] <= spawn_x;
            lfsr       <= lfsr_next;
          end
          idx <= idx + 4'd1;
        end
        LATCH: begin
          d   <= d_in;
          idx <= '0;
        end
        SCROLL: begin
          if (wrap) begin
            y_tab[idx] <= 9'(ny - 10'(SCREEN_Y_MAX + 1));
            x_tab[idx] <= spawn_x;
            lfsr       <= lfsr_next;
          end else begin
            y_tab[idx] <= ny[8:0];
          end
          idx <= idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef SCROLL_SCORE_EN
  logic [15:0] score;
  logic [16:0] score_sum;

  assign score_sum  = {1'b0, score} + {12'd0, d_in};
  assign countingss = score;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      score <= '0;
    end else if (state == IDLE && state_next == LOAD) begin
      score <= '0;
    end else if (state == LATCH) begin
      score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end
  end
`else
  assign countingss = '0;
`endif

endmodule

// File: tb/tb_platform_scroller.sv
// Self-checking bench for platform_scroller: a reference model of the table
// predicts the result of every load/scroll, the driver queues it, and a
// monitor compares it when the DUT returns to idle.

module tb_platform_scroller;

  localparam int NP = 16;

  logic             Clk;
  logic             Reset;
  logic             loadplat;
  logic             refresh_en;
  logic [9:0]       plat_temp_Y;
  logic [NP*9-1:0]  plat_x;
  logic [NP*9-1:0]  plat_y;
  logic [8:0]       plat_sizeX;
  logic [8:0]       plat_sizeY;
  logic             trigger;
  logic             busy;
  logic [15:0]      countingss;

  platform_scroller dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .loadplat    (loadplat),
    .refresh_en  (refresh_en),
    .plat_temp_Y (plat_temp_Y),
    .plat_x      (plat_x),
    .plat_y      (plat_y),
    .plat_sizeX  (plat_sizeX),
    .plat_sizeY  (plat_sizeY),
    .trigger     (trigger),
    .busy        (busy),
    .countingss  (countingss)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [8:0]  mx [NP];
  logic [8:0]  my [NP];
  logic [15:0] m_lfsr;
  int          m_score;

  function automatic logic [15:0] lfsr_adv(input logic [15:0] l);
    return {l[14:0], ^(l & 16'hB400)};
  endfunction

  task automatic model_spawn(output logic [8:0] x);
    x      = 9'((40 + int'(m_lfsr[8:0])) % 512);
    m_lfsr = lfsr_adv(m_lfsr);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      mx[i] = '0;
      my[i] = '0;
    end
    m_lfsr  = 16'hACE1;
    m_score = 0;
  endtask

  task automatic model_load();
    m_lfsr  = 16'hACE1;
    m_score = 0;
    for (int i = 0; i < NP; i++) begin
      my[i] = 9'(479 - 30 * i);
      if (i == 0) mx[i] = 9'd320;
      else        model_spawn(mx[i]);
    end
  endtask

  task automatic model_scroll(input logic [9:0] v);
    int mag, dd, ny;
    mag = (int'(v) >= 512) ? 1024 - int'(v) : 0;
    dd  = (mag > 31) ? 31 : mag;
    m_score = (m_score + dd > 65535) ? 65535 : m_score + dd;
    for (int i = 0; i < NP; i++) begin
      ny = int'(my[i]) + dd;
      if (ny > 479) begin
        my[i] = 9'(ny - 480);
        model_spawn(mx[i]);
      end else begin
        my[i] = 9'(ny);
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct packed {
    bit              is_scroll;
    logic [NP*9-1:0] x;
    logic [NP*9-1:0] y;
    logic [15:0]     score;
  } item_t;

  item_t q[$];
  bit    mute = 1'b1;

  task automatic push_item(input bit is_scroll);
    item_t it;
    it.is_scroll = is_scroll;
    for (int i = 0; i < NP; i++) begin
      it.x[9*i +: 9] = mx[i];
      it.y[9*i +: 9] = my[i];
    end
`ifdef SCROLL_SCORE_EN
    it.score = 16'(m_score);
`else
    it.score = 16'd0;
`endif
    q.push_back(it);
  endtask

  initial begin : monitor
    bit    prev_busy = 1'b0;
    bit    trig_seen = 1'b0;
    int    busy_len  = 0;
    item_t it;
    forever begin
      @(negedge Clk);
      if (busy) begin
        busy_len++;
        if (trigger) trig_seen = 1'b1;
      end
      if (prev_busy && !busy && !mute) begin
        if (q.size() == 0) begin
          check("sb_unexpected_op", 1, 0);
        end else begin
          it = q.pop_front();
          for (int i = 0; i < NP; i++) begin
            check($sformatf("sb_x[%0d]", i), 32'(plat_x[9*i +: 9]), 32'(it.x[9*i +: 9]));
            check($sformatf("sb_y[%0d]", i), 32'(plat_y[9*i +: 9]), 32'(it.y[9*i +: 9]));
          end
          check("sb_score", 32'(countingss), 32'(it.score));
          check("sb_trigger_seen", 32'(trig_seen), 32'(it.is_scroll));
          if (!it.is_scroll) check("sb_load_cycles", busy_len, 16);
        end
      end
      if (!busy) begin
        busy_len  = 0;
        trig_seen = 1'b0;
      end
      prev_busy = busy;
    end
  end

  // ---------------- driver ----------------
  task automatic wait_idle(input int bound);
    int n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (busy && n < bound);
    check("idle_timeout", 32'(busy), 0);
  endtask

  task automatic finish_scroll(input int hold);
    repeat (hold) begin
      @(negedge Clk);
      check("trig_hold", 32'(trigger), 1);
    end
    @(negedge Clk);
    refresh_en = 1'b0;
    @(posedge Clk);
    #1;
    check("trig_drop", 32'(trigger), 0);
    check("busy_drop", 32'(busy), 0);
  endtask

  task automatic do_load();
    @(negedge Clk);
    loadplat = 1'b1;
    model_load();
    push_item(1'b0);
    @(negedge Clk);
    loadplat = 1'b0;
    wait_idle(40);
  endtask

  task automatic do_scroll(input logic [9:0] v, input bit early, input int hold);
    int n = 0;
    @(negedge Clk);
    refresh_en  = 1'b1;
    plat_temp_Y = v;
    model_scroll(v);
    push_item(1'b1);
    if (early) begin
      @(negedge Clk);
      refresh_en = 1'b0;
      wait_idle(40);
    end else begin
      do begin
        @(posedge Clk);
        #1;
        n++;
      end while (!trigger && n < 40);
      check("trig_latency", n, 18);
      finish_scroll(hold);
    end
  endtask

  initial begin
    int n;
    Reset       = 1'b0;
    loadplat    = 1'b0;
    refresh_en  = 1'b0;
    plat_temp_Y = '0;
    model_reset();
    #23;
    check("rst_x", 32'(plat_x != '0), 0);
    check("rst_y", 32'(plat_y != '0), 0);
    check("rst_trigger", 32'(trigger), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_score", 32'(countingss), 0);
    check("size_x", 32'(plat_sizeX), 20);
    check("size_y", 32'(plat_sizeY), 3);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    mute = 1'b0;

    // Initial layout.
    do_load();
    check("load_y0", 32'(plat_y[8:0]), 479);
    check("load_y1", 32'(plat_y[17:9]), 449);
    check("load_y15", 32'(plat_y[143:135]), 29);
    check("load_x0", 32'(plat_x[8:0]), 320);
    check("load_x1", 32'(plat_x[17:9]), 265);

    // d = 10: platform 0 wraps to the top.
    do_scroll(10'h3F6, 1'b0, 2);
    check("scr_y0", 32'(plat_y[8:0]), 9);
    check("scr_y1", 32'(plat_y[17:9]), 459);
    check("scr_y15", 32'(plat_y[143:135]), 39);

    // Magnitude 64 clamps to 31.
    do_load();
    do_scroll(10'h3C0, 1'b0, 0);
    check("clamp_y15", 32'(plat_y[143:135]), 60);

    // Positive velocity: nothing moves, handshake still completes.
    do_scroll(10'h005, 1'b0, 1);

    // Simultaneous load and refresh: load first, then scroll.
    @(negedge Clk);
    loadplat    = 1'b1;
    refresh_en  = 1'b1;
    plat_temp_Y = 10'h3F6;
    model_load();
    push_item(1'b0);
    model_scroll(10'h3F6);
    push_item(1'b1);
    @(negedge Clk);
    loadplat = 1'b0;
    n = 0;
    do begin
      @(posedge Clk);
      #1;
      n++;
    end while (!trigger && n < 60);
    check("combo_trigger", 32'(trigger), 1);
    finish_scroll(0);

    // Randomized mix of loads, scrolls and early-released scrolls.
    for (int k = 0; k < 24; k++) begin
      int op = $urandom_range(0, 9);
      logic [9:0] v = 10'($urandom_range(0, 1023));
      if (op == 0)      do_load();
      else if (op == 1) do_scroll(v, 1'b1, 0);
      else              do_scroll(v, 1'b0, $urandom_range(0, 3));
    end

    // Reset in the middle of a scroll (SCROLL at idx 7).
    @(negedge Clk);
    mute        = 1'b1;
    refresh_en  = 1'b1;
    plat_temp_Y = 10'h3F6;
    repeat (9) @(posedge Clk);
    #1;
    Reset = 1'b0;
    #1;
    check("abort_x", 32'(plat_x != '0), 0);
    check("abort_y", 32'(plat_y != '0), 0);
    check("abort_trigger", 32'(trigger), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_score", 32'(countingss), 0);
    refresh_en = 1'b0;
    model_reset();
    q.delete();
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    mute = 1'b0;

    // Score accumulation over three d=10 scrolls.
    repeat (3) do_scroll(10'h3F6, 1'b0, 0);
`ifdef SCROLL_SCORE_EN
    check("score_30", 32'(countingss), 30);
`else
    check("score_off", 32'(countingss), 0);
`endif

    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge Clk);
      n++;
    end
    check("sb_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
